// File: rtl/smul_pkg.sv
// Shared types and constants for the shift-add signed multiplier datapath.
// Optional feature macro used by this slice: SMUL_VALID_EN.
package smul_pkg;

    localparam int unsigned SMUL_WIDTH = 8;
    localparam int unsigned SMUL_CNT_W = $clog2(SMUL_WIDTH + 1);

    typedef enum logic [2:0] {
        OpHold,
        OpLoad,
        OpAdd,
        OpSub,
        OpShift
    } smul_op_e;

    // Exactly one datapath op per cycle, highest priority first.
    function automatic smul_op_e smul_op_sel(input logic load, input logic add,
                                             input logic sub, input logic shift);
        if (load)  return OpLoad;
        if (add)   return OpAdd;
        if (sub)   return OpSub;
        if (shift) return OpShift;
        return OpHold;
    endfunction

endpackage

// File: rtl/smul_if.sv
// Controller <-> datapath bus for the shift-add signed multiplier.
// SMUL_VALID_EN adds the product_valid flag.
interface smul_if #(
    parameter int unsigned WIDTH = smul_pkg::SMUL_WIDTH
);
    logic                 Load;
    logic                 Shift;
    logic                 Add;
    logic                 Sub;
    logic                 Enable;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 m0;
    logic                 End;
    logic [2*WIDTH-1:0]   product;
`ifdef SMUL_VALID_EN
    logic                 product_valid;

    modport master (
        output Load, Shift, Add, Sub, Enable, a_in, b_in,
        input  m0, End, product, product_valid
    );
    modport slave (
        input  Load, Shift, Add, Sub, Enable, a_in, b_in,
        output m0, End, product, product_valid
    );
`else
    modport master (
        output Load, Shift, Add, Sub, Enable, a_in, b_in,
        input  m0, End, product
    );
    modport slave (
        input  Load, Shift, Add, Sub, Enable, a_in, b_in,
        output m0, End, product
    );
`endif
endinterface

// File: rtl/smul_bitcnt.sv
// Loadable bit counter saturating at WIDTH, with the End (cnt == WIDTH-1) decode.
// SMUL_VALID_EN adds the o_sat output (cnt == WIDTH).
module smul_bitcnt
    import smul_pkg::*;
#(
    parameter  int unsigned WIDTH = SMUL_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_enable,
`ifdef SMUL_VALID_EN
    output logic o_sat,
`endif
    output logic o_end
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_load) begin
            w_cnt_d = '0;
        end else if (i_enable && (r_cnt != CntMax)) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end
    end

    // Idles at WIDTH so End stays low until the first Load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= CntMax;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_end = (r_cnt == (CntMax - CNT_W'(1)));
`ifdef SMUL_VALID_EN
    assign o_sat = (r_cnt == CntMax);
`endif

endmodule

// File: rtl/smul_datapath.sv
// Shift-add signed multiplier datapath: M, ACC (one guard bit), Q and the bit counter.
// SMUL_VALID_EN adds a registered product_valid flag.
module smul_datapath
    import smul_pkg::*;
#(
    parameter int unsigned WIDTH = SMUL_WIDTH
) (
    input logic   clk,
    input logic   reset,
    smul_if.slave bus
);

    logic [WIDTH-1:0] r_m;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_m_d;
    logic [WIDTH:0]   w_acc_d;
    logic [WIDTH-1:0] w_q_d;
    logic [WIDTH:0]   w_m_ext;
    smul_op_e         w_op;
    logic             w_end;

    assign w_op    = smul_op_sel(bus.Load, bus.Add, bus.Sub, bus.Shift);
    assign w_m_ext = {r_m[WIDTH-1], r_m};

    always_comb begin
        w_m_d   = r_m;
        w_acc_d = r_acc;
        w_q_d   = r_q;
        unique case (w_op)
            OpLoad: begin
                w_m_d   = bus.a_in;
                w_q_d   = bus.b_in;
                w_acc_d = '0;
            end
            OpAdd:   w_acc_d = r_acc + w_m_ext;
            OpSub:   w_acc_d = r_acc - w_m_ext;
            // Arithmetic right shift of {ACC,Q}; the guard bit carries the sign.
            OpShift: {w_acc_d, w_q_d} = {r_acc[WIDTH], r_acc, r_q[WIDTH-1:1]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
        end else begin
            r_m   <= w_m_d;
            r_acc <= w_acc_d;
            r_q   <= w_q_d;
        end
    end

`ifdef SMUL_VALID_EN
    logic w_sat;
    logic r_valid;

    smul_bitcnt #(
        .WIDTH    (WIDTH)
    ) u_bitcnt (
        .clk      (clk),
        .reset    (reset),
        .i_load   (bus.Load),
        .i_enable (bus.Enable),
        .o_sat    (w_sat),
        .o_end    (w_end)
    );

    // The Shift taken with a saturated counter is the final MSB shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (w_op == OpLoad) begin
            r_valid <= 1'b0;
        end else if ((w_op == OpShift) && w_sat) begin
            r_valid <= 1'b1;
        end
    end

    assign bus.product_valid = r_valid;
`else
    smul_bitcnt #(
        .WIDTH    (WIDTH)
    ) u_bitcnt (
        .clk      (clk),
        .reset    (reset),
        .i_load   (bus.Load),
        .i_enable (bus.Enable),
        .o_end    (w_end)
    );
`endif

    assign bus.m0      = r_q[0];
    assign bus.End     = w_end;
    assign bus.product = {r_acc[WIDTH-1:0], r_q};

endmodule

// File: tb/tb_smul_datapath.sv
// Self-checking bench for smul_datapath: the bench plays the controller and scores products.
module tb_smul_datapath;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    smul_if #(.WIDTH(W)) bus ();

    smul_datapath #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [2*W-1:0] exp_q[$];
    int             n_cmp = 0;
    int             n_err = 0;
    int             m_cnt;
    logic           m_valid;
    logic [2*W-1:0] last_prod;

    // One controller cycle: drive ops, clock, update counter model, check End.
    task automatic step(input logic ld, input logic sh, input logic ad, input logic sb,
                        input logic en);
        int pre_cnt;
        bus.Load   = ld;
        bus.Shift  = sh;
        bus.Add    = ad;
        bus.Sub    = sb;
        bus.Enable = en;
        pre_cnt    = m_cnt;
        @(posedge clk);
        #1;
        if (ld) begin
            m_cnt   = 0;
            m_valid = 1'b0;
        end else begin
            if (en && m_cnt < int'(W)) m_cnt = m_cnt + 1;
            if (sh && !ad && !sb && pre_cnt == int'(W)) m_valid = 1'b1;
        end
        n_cmp++;
        if (bus.End !== (m_cnt == int'(W) - 1)) begin
            n_err++;
            $display("FAIL end_flag: got %b want %b (cnt model %0d)", bus.End,
                     (m_cnt == int'(W) - 1), m_cnt);
        end
`ifdef SMUL_VALID_EN
        n_cmp++;
        if (bus.product_valid !== m_valid) begin
            n_err++;
            $display("FAIL product_valid: got %b want %b", bus.product_valid, m_valid);
        end
`endif
        bus.Load   = 1'b0;
        bus.Shift  = 1'b0;
        bus.Add    = 1'b0;
        bus.Sub    = 1'b0;
        bus.Enable = 1'b0;
    endtask

    // Load then run nbits of the LSB-first loop (Add if m0, then Shift+Enable).
    task automatic partial(input logic [W-1:0] a, input logic [W-1:0] b, input int nbits);
        bus.a_in = a;
        bus.b_in = b;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            n_cmp++;
            if (bus.m0 !== b[i]) begin
                n_err++;
                $display("FAIL m0_bit%0d: got %b want %b", i, bus.m0, b[i]);
            end
            if (bus.m0) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic run_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [2*W-1:0] e;
        logic [2*W-1:0]        want;
        e = a * b;
        exp_q.push_back(e);
        partial(a, b, W - 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.m0 !== b[W-1]) begin
            n_err++;
            $display("FAIL m0_msb: got %b want %b", bus.m0, b[W-1]);
        end
        if (bus.m0) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got product %h want a queued entry", bus.product);
        end else begin
            want = exp_q.pop_front();
            if (bus.product !== want) begin
                n_err++;
                $display("FAIL product %0d x %0d: got %h want %h", a, b, bus.product, want);
            end
            last_prod = want;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_cnt = int'(W);
        m_valid = 1'b0;
        #12;
        n_cmp++;
        if (bus.product !== '0 || bus.End !== 1'b0 || bus.m0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got prod=%h End=%b m0=%b want 0/0/0",
                     bus.product, bus.End, bus.m0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Enable while idle must not wrap the saturated counter into End.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_basic();
        run_mul(8'sd3, -8'sd2);
        run_mul(8'sd7, 8'sd5);
    endtask

    task automatic test_boundary();
        run_mul(-8'sd128, -8'sd128);
        run_mul(-8'sd128, 8'sd127);
        run_mul(8'sd0, -8'sd1);
        run_mul(8'sd127, 8'sd127);
        run_mul(8'sd5, 8'sd0);
    endtask

    task automatic test_hold();
        run_mul(-8'sd19, 8'sd23);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (bus.product !== last_prod) begin
                n_err++;
                $display("FAIL product_hold: got %h want %h", bus.product, last_prod);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_mul(W'($urandom_range(255)), W'($urandom_range(255)));
        end
    endtask

    task automatic test_abort();
        partial(8'sd100, -8'sd77, 4);
        run_mul(-8'sd9, 8'sd11);
    endtask

    task automatic test_mid_reset();
        partial(8'sd45, 8'sd6, 3);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.product !== '0 || bus.End !== 1'b0 || bus.m0 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got prod=%h End=%b m0=%b want 0/0/0",
                     bus.product, bus.End, bus.m0);
        end
        m_cnt = int'(W);
        m_valid = 1'b0;
        #2;
        reset = 1'b0;
        run_mul(-8'sd3, -8'sd43);
    endtask

    initial begin
        bus.Load   = 1'b0;
        bus.Shift  = 1'b0;
        bus.Add    = 1'b0;
        bus.Sub    = 1'b0;
        bus.Enable = 1'b0;
        bus.a_in   = '0;
        bus.b_in   = '0;
        test_reset();
        test_basic();
        test_boundary();
        test_hold();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
